// File: rtl/orca_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | orca_pkg : shared console-colour types, SGR constants, apply helper  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package orca_pkg;

  typedef logic [7:0] ubyte_t;

  typedef struct packed {
    logic       fg_set;
    logic [3:0] fg;
    logic       bold;
    logic       ul;
  } ansi_attr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ESC  = 2'd1,
    ST_CSI  = 2'd2
  } ansi_state_e;

  localparam ubyte_t ANSI_ESC = 8'h1B;
  localparam ubyte_t ANSI_CSI = 8'h5B;
  localparam ubyte_t ANSI_SGR = 8'h6D;
  localparam ubyte_t ANSI_SEP = 8'h3B;

  localparam logic [7:0] SGR_RESET          = 8'd0;
  localparam logic [7:0] SGR_BOLD           = 8'd1;
  localparam logic [7:0] SGR_UL             = 8'd4;
  localparam logic [7:0] SGR_BOLD_OFF       = 8'd22;
  localparam logic [7:0] SGR_UL_OFF         = 8'd24;
  localparam logic [7:0] SGR_FG_BASE        = 8'd30;
  localparam logic [7:0] SGR_FG_DEFAULT     = 8'd39;
  localparam logic [7:0] SGR_FG_BRIGHT_BASE = 8'd90;

  function automatic ansi_attr_t sgr_apply(input ansi_attr_t a, input logic [7:0] code);
    ansi_attr_t r;
    r = a;
    if (code == SGR_RESET) begin
      r = '0;
    end else if (code == SGR_BOLD) begin
      r.bold = 1'b1;
    end else if (code == SGR_BOLD_OFF) begin
      r.bold = 1'b0;
    end else if (code == SGR_UL) begin
      r.ul = 1'b1;
    end else if (code == SGR_UL_OFF) begin
      r.ul = 1'b0;
    end else if (code >= SGR_FG_BASE && code <= SGR_FG_BASE + 8'd7) begin
      r.fg_set = 1'b1;
      r.fg     = 4'(code - SGR_FG_BASE);
    end else if (code >= SGR_FG_BRIGHT_BASE && code <= SGR_FG_BRIGHT_BASE + 8'd7) begin
      // bright colours occupy palette slots 8..15
      r.fg_set = 1'b1;
      r.fg     = {1'b1, 3'(code - SGR_FG_BRIGHT_BASE)};
    end else if (code == SGR_FG_DEFAULT) begin
      r.fg_set = 1'b0;
      r.fg     = '0;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/orca_ansi_param_acc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | orca_ansi_param_acc : decimal SGR parameter accumulator, sat. at 255 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module orca_ansi_param_acc (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic [3:0] digit_i,
  output logic [7:0] acc_o
);

  logic [7:0]  acc_q;
  logic [7:0]  acc_d;
  logic [11:0] w_sum;

  always_comb begin
    w_sum = 12'(acc_q) * 12'd10 + 12'(digit_i);
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (load_i) begin
      acc_d = (w_sum > 12'd255) ? 8'hFF : w_sum[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/orca_ansi_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | orca_ansi_decoder : strips ANSI SGR sequences, tags chars with attrs |
// | Optional statistics counters: ORCA_ANSI_STATS_EN    Rev 1.0          |
// +----------------------------------------------------------------------+
module orca_ansi_decoder
  import orca_pkg::*;
#(
  parameter int MAX_SEQ_LEN = 16
`ifdef ORCA_ANSI_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  ubyte_t     in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output ubyte_t     out_data,
  output ansi_attr_t out_attr,
  output ansi_attr_t cur_attr,
  output logic       err_pulse
`ifdef ORCA_ANSI_STATS_EN
  ,
  output logic [CNT_W-1:0] seq_count,
  output logic [CNT_W-1:0] err_count
`endif
);

  localparam int CW = $clog2(MAX_SEQ_LEN + 2);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_SEQ_LEN);

  ansi_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic          out_valid_q;
  ubyte_t        out_data_q;
  ansi_attr_t    out_attr_q;
  ansi_attr_t    cur_attr_q;
  logic          err_q;

  logic          w_accept;
  logic          w_is_digit;
  logic          w_is_final;
  logic [CW-1:0] w_cnt_next;
  logic          w_overflow;
  logic          w_err;
  logic          w_done;
  logic          w_acc_clr;
  logic          w_acc_load;
  logic [7:0]    w_acc;

  // Only a character waiting in IDLE can be blocked by a full output stage
  assign in_ready   = (state_q != ST_IDLE) | ~out_valid_q | out_ready;
  assign w_accept   = in_valid & in_ready;
  assign w_is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign w_is_final = (in_data >= 8'h40) && (in_data <= 8'h7E);
  assign w_cnt_next = cnt_q + CW'(1);
  assign w_overflow = (w_cnt_next > MAX_CNT);

  always_comb begin
    w_err  = 1'b0;
    w_done = 1'b0;
    if (w_accept) begin
      case (state_q)
        ST_ESC: w_err = (in_data != ANSI_CSI);
        ST_CSI: begin
          if (w_overflow)                           w_err  = 1'b1;
          else if (w_is_digit || in_data == ANSI_SEP) w_err  = 1'b0;
          else if (in_data == ANSI_SGR)             w_done = 1'b1;
          else if (!w_is_final)                     w_err  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_acc_clr  = w_accept & ((state_q != ST_CSI) | (in_data == ANSI_SEP));
  assign w_acc_load = w_accept & (state_q == ST_CSI) & w_is_digit & ~w_overflow;

  orca_ansi_param_acc u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (w_acc_clr),
    .load_i  (w_acc_load),
    .digit_i (in_data[3:0]),
    .acc_o   (w_acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_attr_q  <= '0;
      cur_attr_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= w_err;
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (w_accept) begin
        case (state_q)
          ST_IDLE: begin
            if (in_data == ANSI_ESC) begin
              state_q <= ST_ESC;
              cnt_q   <= '0;
            end else begin
              out_valid_q <= 1'b1;
              out_data_q  <= in_data;
              out_attr_q  <= cur_attr_q;
            end
          end
          ST_ESC: begin
            cnt_q   <= w_cnt_next;
            state_q <= (in_data == ANSI_CSI) ? ST_CSI : ST_IDLE;
          end
          ST_CSI: begin
            cnt_q <= w_cnt_next;
            if (w_overflow) begin
              state_q <= ST_IDLE;
            end else if (w_is_digit) begin
              state_q <= ST_CSI;
            end else if (in_data == ANSI_SEP) begin
              cur_attr_q <= sgr_apply(cur_attr_q, w_acc);
            end else if (w_done) begin
              cur_attr_q <= sgr_apply(cur_attr_q, w_acc);
              state_q    <= ST_IDLE;
            end else if (in_data == ANSI_ESC) begin
              // a fresh ESC abandons the broken sequence and starts a new one
              state_q <= ST_ESC;
              cnt_q   <= '0;
            end else begin
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_attr  = out_attr_q;
  assign cur_attr  = cur_attr_q;
  assign err_pulse = err_q;

`ifdef ORCA_ANSI_STATS_EN
  logic [CNT_W-1:0] seq_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (w_done) seq_cnt_q <= seq_cnt_q + CNT_W'(1);
      if (w_err)  err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign seq_count = seq_cnt_q;
  assign err_count = err_cnt_q;
`endif

endmodule
`default_nettype wire
